// File: rtl/mod_seq_monitor_if.sv
// Sample/status bundle between a mod-n counter and its sequence monitor.
// The monitor uses the slave modport; the driver of the counter value uses the master modport.
interface mod_seq_monitor_if #(
    parameter int unsigned W   = 4,
    parameter int unsigned MW  = 4,
    parameter int unsigned ECW = 8
);
    logic           en;
    logic [W-1:0]   q_in;
    logic           err_clr;
    logic           locked;
    logic           wrap_pulse;
    logic [MW-1:0]  wrap_cnt;
    logic           err;
    logic [ECW-1:0] err_cnt;

    modport master (
        output en, q_in, err_clr,
        input  locked, wrap_pulse, wrap_cnt, err, err_cnt
    );

    modport slave (
        input  en, q_in, err_clr,
        output locked, wrap_pulse, wrap_cnt, err, err_cnt
    );
endinterface

// File: rtl/mod_seq_monitor.sv
// Locks onto a mod-N count sequence, emits wrap pulses/count, and tracks sequence errors.
// Optional macro MON_STALL_OK_EN: accept a repeated value while locked as a counter hold.
module mod_seq_monitor #(
    parameter int unsigned N   = 4,
    parameter int unsigned W   = 4,
    parameter int unsigned M   = 16,
    parameter int unsigned MW  = 4,
    parameter int unsigned ECW = 8
) (
    input logic               clk,
    input logic               rst,
    mod_seq_monitor_if.slave  bus
);
    localparam logic StAcq  = 1'b0;
    localparam logic StLock = 1'b1;

    localparam logic [W-1:0]  LastVal  = W'(N - 1);
    localparam logic [MW-1:0] LastWrap = MW'(M - 1);

    logic           state_q, state_d;
    logic [W-1:0]   prev_q, prev_d;
    logic           wrap_q, wrap_d;
    logic [MW-1:0]  wrap_cnt_q, wrap_cnt_d;
    logic           err_q, err_d;
    logic [ECW-1:0] err_cnt_q, err_cnt_d;

    logic [W-1:0]   expected;
    logic           hold_ok;
    logic           err_det;

    assign expected = (prev_q == LastVal) ? '0 : prev_q + 1'b1;

`ifdef MON_STALL_OK_EN
    assign hold_ok = (bus.q_in == prev_q);
`else
    assign hold_ok = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        wrap_d     = 1'b0;
        wrap_cnt_d = wrap_cnt_q;
        err_det    = 1'b0;

        if (bus.en) begin
            if (state_q == StAcq) begin
                if (bus.q_in == '0) begin
                    state_d = StLock;
                    prev_d  = '0;
                end
            end else begin
                if (bus.q_in == expected) begin
                    prev_d = bus.q_in;
                    // With N=1 prev is always N-1, so every accepted 0 is a wrap.
                    if (prev_q == LastVal && bus.q_in == '0) begin
                        wrap_d     = 1'b1;
                        wrap_cnt_d = (wrap_cnt_q == LastWrap) ? '0 : wrap_cnt_q + 1'b1;
                    end
                end else if (!hold_ok) begin
                    err_det = 1'b1;
                    state_d = StAcq;
                end
            end
        end
    end

    always_comb begin
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (bus.err_clr) begin
            err_d     = 1'b0;
            err_cnt_d = '0;
        end
        // A fresh error beats a simultaneous clear and counts from the cleared value.
        if (err_det) begin
            err_d = 1'b1;
            if (bus.err_clr) begin
                err_cnt_d = ECW'(1);
            end else if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StAcq;
            prev_q     <= '0;
            wrap_q     <= 1'b0;
            wrap_cnt_q <= '0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            wrap_q     <= wrap_d;
            wrap_cnt_q <= wrap_cnt_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.locked     = (state_q == StLock);
    assign bus.wrap_pulse = wrap_q;
    assign bus.wrap_cnt   = wrap_cnt_q;
    assign bus.err        = err_q;
    assign bus.err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_mod_seq_monitor.sv
// Directed table-driven bench for mod_seq_monitor (N=4, M=16, ECW=2 so saturation is reachable).
// Honours MON_STALL_OK_EN for the repeated-value expectations.
module tb_mod_seq_monitor;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mod_seq_monitor_if #(.W(4), .MW(4), .ECW(2)) bus ();

    mod_seq_monitor #(.N(4), .W(4), .M(16), .MW(4), .ECW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [3:0] q;
        logic       clr;
        logic       l;
        logic       w;
        logic [3:0] wc;
        logic       e;
        logic [1:0] ec;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic en, input logic [3:0] q, input logic clr, input logic l,
                       input logic w, input logic [3:0] wc, input logic e, input logic [1:0] ec);
        vec_t v;
        v.en = en; v.q = q; v.clr = clr; v.l = l; v.w = w; v.wc = wc; v.e = e; v.ec = ec;
        tbl.push_back(v);
    endtask

    task automatic apply(input logic en, input logic [3:0] q, input logic clr);
        bus.en      = en;
        bus.q_in    = q;
        bus.err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic l, input logic w, input logic [3:0] wc,
                         input logic e, input logic [1:0] ec);
        checks++;
        if (bus.locked !== l || bus.wrap_pulse !== w || bus.wrap_cnt !== wc ||
            bus.err !== e || bus.err_cnt !== ec) begin
            errors++;
            $display("FAIL %s: got locked=%b wrap=%b wcnt=%0d err=%b ecnt=%0d, want locked=%b wrap=%b wcnt=%0d err=%b ecnt=%0d",
                     name, bus.locked, bus.wrap_pulse, bus.wrap_cnt, bus.err, bus.err_cnt,
                     l, w, wc, e, ec);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.en = 1'b0; bus.q_in = '0; bus.err_clr = 1'b0;

        // Test 1: acquire and first wrap
        add(1, 3, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 0, 0);
        add(1, 2, 0, 1, 0, 0, 0, 0);
        add(1, 3, 0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 1, 1, 1, 0, 0);
        add(1, 1, 0, 1, 0, 1, 0, 0);
        // Test 3: skip error, relock, erroneous 0 must not relock
        add(1, 2, 0, 1, 0, 1, 0, 0);
        add(1, 3, 0, 1, 0, 1, 0, 0);
        add(1, 0, 0, 1, 1, 2, 0, 0);
        add(1, 1, 0, 1, 0, 2, 0, 0);
        add(1, 3, 0, 0, 0, 2, 1, 1);
        add(1, 2, 0, 0, 0, 2, 1, 1);
        add(1, 0, 0, 1, 0, 2, 1, 1);
        add(1, 1, 0, 1, 0, 2, 1, 1);
        add(1, 0, 0, 0, 0, 2, 1, 2);
        add(1, 1, 0, 0, 0, 2, 1, 2);
        add(1, 0, 0, 1, 0, 2, 1, 2);
        // Test 4: out-of-range errors, saturation at 3
        add(1, 5, 0, 0, 0, 2, 1, 3);
        add(1, 0, 0, 1, 0, 2, 1, 3);
        add(1, 5, 0, 0, 0, 2, 1, 3);
        add(1, 0, 0, 1, 0, 2, 1, 3);
        add(1, 5, 0, 0, 0, 2, 1, 3);
        // Test 5: clear, build to 2, clear collides with error, clear alone
        add(1, 0, 1, 1, 0, 2, 0, 0);
        add(1, 2, 0, 0, 0, 2, 1, 1);
        add(1, 0, 0, 1, 0, 2, 1, 1);
        add(1, 2, 0, 0, 0, 2, 1, 2);
        add(1, 0, 0, 1, 0, 2, 1, 2);
        add(1, 3, 1, 0, 0, 2, 1, 1);
        add(1, 0, 1, 1, 0, 2, 0, 0);
        // Test 6: wrap, then en=0 holds and kills the pulse
        add(1, 1, 0, 1, 0, 2, 0, 0);
        add(1, 2, 0, 1, 0, 2, 0, 0);
        add(1, 3, 0, 1, 0, 2, 0, 0);
        add(1, 0, 0, 1, 1, 3, 0, 0);
        add(0, 2, 0, 1, 0, 3, 0, 0);
        add(0, 0, 0, 1, 0, 3, 0, 0);
        add(0, 7, 0, 1, 0, 3, 0, 0);
        add(1, 1, 0, 1, 0, 3, 0, 0);
`ifdef MON_STALL_OK_EN
        add(1, 1, 0, 1, 0, 3, 0, 0);
        add(1, 2, 0, 1, 0, 3, 0, 0);
        add(0, 5, 1, 1, 0, 3, 0, 0);
`else
        add(1, 1, 0, 0, 0, 3, 1, 1);
        add(1, 2, 0, 0, 0, 3, 1, 1);
        add(0, 5, 1, 0, 0, 3, 0, 0);
`endif

        rst = 1'b1;
        apply(0, 0, 0);
        check("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].en, tbl[i].q, tbl[i].clr);
            check($sformatf("vec%0d", i), tbl[i].l, tbl[i].w, tbl[i].wc, tbl[i].e, tbl[i].ec);
        end

        // Reset mid-run with live inputs: rst must override and clear wrap_cnt
        rst = 1'b1;
        apply(1, 2, 0);
        check("rst_override", 0, 0, 0, 0, 0);
        rst = 1'b0;
        apply(1, 0, 0);
        check("relock_after_rst", 1, 0, 0, 0, 0);

        // Test 2: 16 full sequences, wrap_cnt rolls 15 -> 0
        for (int k = 1; k <= 16; k++) begin
            for (int v = 1; v <= 3; v++) begin
                apply(1, 4'(v), 0);
                check($sformatf("seq%0d_v%0d", k, v), 1, 0, 4'((k - 1) % 16), 0, 0);
            end
            apply(1, 0, 0);
            check($sformatf("seq%0d_wrap", k), 1, 1, 4'(k % 16), 0, 0);
        end
        apply(0, 9, 0);
        check("post_roll_idle", 1, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
